// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART: baud generator, TX/RX framing FSMs with optional parity,
// byte FIFOs in both directions, sticky error flags and a registered level irq.

module uart_fifo_ctrl_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_fifo_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_uart,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [3:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] readed_data,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        irq
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic                 tx_en, rx_en, parity_en, parity_odd, two_stop, rx_irq_en, tx_irq_en;
  logic [DIV_WIDTH-1:0] div, baud_cnt;
  logic                 parity_err, frame_err, overrun;
  logic                 wr, rd, soft_rst, baud_run, tick;
  logic [1:0]           reg_sel;
  logic [31:0]          rdata;

  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_line, tx_bit_end;
  logic [7:0]           tx_head, tx_data;
  logic [CW-1:0]        tx_count;
  logic [OSW-1:0]       tx_os;
  logic [2:0]           tx_bit;
  tx_state_t            tx_state, tx_next;

  logic                 rx_push, rx_pop, rx_full, rx_empty, rx_bit_tick;
  logic                 rx_meta, rx_sync, rx_prev, rx_par;
  logic                 set_pe, set_fe, set_ovr;
  logic [7:0]           rx_head, rx_shift;
  logic [CW-1:0]        rx_count;
  logic [OSW-1:0]       rx_os;
  logic [2:0]           rx_bit;
  rx_state_t            rx_state, rx_next;

  logic                 unused_bits;
  assign unused_bits = ^{addr[1:0], write_data[15:8], tx_count};

  assign reg_sel  = addr[3:2];
  assign wr       = sel_uart & mem_write;
  assign rd       = sel_uart & mem_read & ~mem_write;
  assign soft_rst = wr && (reg_sel == 2'd3) && write_data[2];
  assign tx_push  = wr && (reg_sel == 2'd0);
  assign rx_pop   = rd && (reg_sel == 2'd1) && !rx_empty;

  uart_fifo_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(soft_rst), .push(tx_push), .push_data(write_data[7:0]),
    .pop(tx_pop), .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(soft_rst), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      parity_en  <= 1'b0;
      parity_odd <= 1'b0;
      two_stop   <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      div        <= DIV_WIDTH'(DEFAULT_DIV);
    end else if (wr && reg_sel == 2'd3) begin
      tx_en      <= write_data[0];
      rx_en      <= write_data[1];
      parity_en  <= write_data[3];
      parity_odd <= write_data[4];
      two_stop   <= write_data[5];
      rx_irq_en  <= write_data[6];
      tx_irq_en  <= write_data[7];
      div        <= write_data[16 +: DIV_WIDTH];
    end
  end

  // a frame already on the wire keeps the baud running after tx_en drops
  assign baud_run = tx_en | rx_en | (tx_state != TX_IDLE);
  assign tick     = baud_run && (baud_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                baud_cnt <= '0;
    else if (!baud_run || tick) baud_cnt <= '0;
    else                       baud_cnt <= baud_cnt + DIV_WIDTH'(1);
  end

  assign tx_bit_end = tick && (tx_os == OS_LAST);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE: if (tx_en && !tx_empty) begin
        tx_next = TX_START;
        tx_pop  = 1'b1;
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_data[tx_bit];
        if (tx_bit_end && tx_bit == 3'd7) tx_next = parity_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_line = ^tx_data ^ parity_odd;
        if (tx_bit_end) tx_next = TX_STOP;
      end
      TX_STOP: if (tx_bit_end && (tx_bit == 3'd1 || !two_stop)) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= soft_rst ? TX_IDLE : tx_next;
      tx_out   <= soft_rst ? 1'b1 : tx_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= '0;
      tx_os   <= '0;
      tx_bit  <= '0;
    end else begin
      if (tx_pop) tx_data <= tx_head;
      if (soft_rst || tx_state != tx_next) begin
        tx_os  <= '0;
        tx_bit <= '0;
      end else if (tick && tx_state != TX_IDLE) begin
        if (tx_os == OS_LAST) begin
          tx_os  <= '0;
          tx_bit <= tx_bit + 3'd1;
        end else begin
          tx_os <= tx_os + OSW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_bit_tick = tick && (rx_os == OS_LAST);

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    set_pe  = 1'b0;
    set_fe  = 1'b0;
    set_ovr = 1'b0;
    if (!rx_en) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:   if (rx_prev && !rx_sync) rx_next = RX_START;
        RX_START:  if (tick && rx_os == OS_HALF) rx_next = rx_sync ? RX_IDLE : RX_DATA;
        RX_DATA:   if (rx_bit_tick && rx_bit == 3'd7) rx_next = parity_en ? RX_PARITY : RX_STOP;
        RX_PARITY: if (rx_bit_tick) rx_next = RX_STOP;
        RX_STOP: if (rx_bit_tick) begin
          rx_next = RX_IDLE;
          if (!rx_sync)                                          set_fe  = 1'b1;
          else if (parity_en && (rx_par != (^rx_shift ^ parity_odd))) set_pe  = 1'b1;
          else if (rx_full && !rx_pop)                           set_ovr = 1'b1;
          else                                                   rx_push = 1'b1;
        end
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= soft_rst ? RX_IDLE : rx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      rx_par   <= 1'b0;
      rx_os    <= '0;
      rx_bit   <= '0;
    end else begin
      if (rx_state == RX_DATA && rx_bit_tick)   rx_shift <= {rx_sync, rx_shift[7:1]};
      if (rx_state == RX_PARITY && rx_bit_tick) rx_par   <= rx_sync;
      if (soft_rst || rx_state != rx_next) begin
        rx_os  <= '0;
        rx_bit <= '0;
      end else if (tick && rx_state != RX_IDLE) begin
        if (rx_os == OS_LAST) begin
          rx_os  <= '0;
          rx_bit <= rx_bit + 3'd1;
        end else begin
          rx_os <= rx_os + OSW'(1);
        end
      end
    end
  end

  // a new error in the same cycle as a write-1-to-clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (soft_rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= set_pe  | (parity_err & ~(wr && reg_sel == 2'd2 && write_data[5]));
      frame_err  <= set_fe  | (frame_err  & ~(wr && reg_sel == 2'd2 && write_data[6]));
      overrun    <= set_ovr | (overrun    & ~(wr && reg_sel == 2'd2 && write_data[7]));
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd1: if (!rx_empty) rdata[7:0] = rx_head;
      2'd2: begin
        rdata[0]    = tx_full;
        rdata[1]    = tx_empty;
        rdata[2]    = rx_full;
        rdata[3]    = rx_empty;
        rdata[4]    = (tx_state != TX_IDLE);
        rdata[5]    = parity_err;
        rdata[6]    = frame_err;
        rdata[7]    = overrun;
        rdata[15:8] = 8'(rx_count);
      end
      2'd3: begin
        rdata[7:0] = {tx_irq_en, rx_irq_en, two_stop, parity_odd, parity_en, 1'b0, rx_en, tx_en};
        rdata[16 +: DIV_WIDTH] = div;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readed_data <= '0;
      irq         <= 1'b0;
    end else begin
      if (rd) readed_data <= rdata;
      irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: bus register access, loopback framing,
// parity/overrun/glitch handling, TX FIFO limits, soft and hard reset.

module tb_uart_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_uart = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] readed_data;
  logic        rx_in, tx_out, irq;
  logic        loop = 1'b0, rx_drv = 1'b1;
  int          vectors = 0, miscompares = 0;
  logic [31:0] rd_val;
  int          w;

  assign rx_in = loop ? tx_out : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.FIFO_DEPTH(8), .OVERSAMPLE(16), .DIV_WIDTH(16), .DEFAULT_DIV(0)) dut (
    .clk(clk), .rst_n(rst_n), .sel_uart(sel_uart), .mem_write(mem_write), .mem_read(mem_read),
    .addr(addr), .write_data(write_data), .readed_data(readed_data),
    .rx_in(rx_in), .tx_out(tx_out), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel_uart = 1'b1; mem_write = 1'b1; addr = a; write_data = d;
    @(negedge clk);
    sel_uart = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel_uart = 1'b1; mem_read = 1'b1; addr = a;
    @(negedge clk);
    sel_uart = 1'b0; mem_read = 1'b0;
    d = readed_data;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // waits for a start bit on tx_out and returns how many cycles it stays low
  task automatic wait_start(output int width);
    int n = 0;
    width = 0;
    while (tx_out !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check("start_seen", 32'(n < 2000), 32'd1);
    while (tx_out === 1'b0 && width < 100) begin @(negedge clk); width++; end
  endtask

  // drives one frame on rx_in at div=1 (32 clocks per bit), two stop bits
  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par);
    rx_drv = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (32) @(negedge clk);
    end
    if (use_par) begin
      rx_drv = par;
      repeat (32) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", readed_data, 32'h0);
    rst_n = 1'b1;
    read_check("rst_status", 4'h8, 32'h0000_000A);
    read_check("rst_ctrl", 4'hC, 32'h0000_0000);

    // loopback of 0x55 at div=1
    loop = 1'b1;
    bus_write(4'hC, 32'h0001_0003);
    bus_write(4'h0, 32'h0000_0055);
    wait_start(w);
    check("start_width", 32'(w >= 31 && w <= 32), 32'd1);
    repeat (330) @(negedge clk);
    read_check("lb_rxdata", 4'h4, 32'h0000_0055);
    read_check("lb_status", 4'h8, 32'h0000_000A);
    read_check("empty_rxdata", 4'h4, 32'h0000_0000);

    // odd parity: 0x07 carries parity 0 on the wire
    bus_write(4'hC, 32'h0001_001B);
    bus_write(4'h0, 32'h0000_0007);
    wait_start(w);
    repeat (272) @(negedge clk);
    check("tx_parity_bit", 32'(tx_out), 32'd0);
    repeat (100) @(negedge clk);
    read_check("par_rxdata", 4'h4, 32'h0000_0007);
    loop = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    read_check("par_err_status", 4'h8, 32'h0000_002A);
    bus_write(4'h8, 32'h0000_0020);
    read_check("par_w1c_status", 4'h8, 32'h0000_000A);

    // overrun: nine frames, no reads
    bus_write(4'hC, 32'h0001_0002);
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    read_check("ovr_status", 4'h8, 32'h0000_0886);
    for (int i = 1; i <= 8; i++) read_check($sformatf("ovr_rx%0d", i), 4'h4, 32'(i));
    bus_write(4'h8, 32'h0000_0080);
    read_check("ovr_w1c_status", 4'h8, 32'h0000_000A);

    // TX FIFO fills with tx disabled, then drains through loopback
    loop = 1'b1;
    bus_write(4'hC, 32'h0001_0000);
    for (int i = 0; i < 10; i++) begin
      bus_write(4'h0, 32'hA0 + 32'(i));
      if (i == 7) read_check("txfull_at8", 4'h8, 32'h0000_0009);
    end
    read_check("txfull_at10", 4'h8, 32'h0000_0009);
    bus_write(4'hC, 32'h0001_0083);
    repeat (3000) @(negedge clk);
    read_check("drain_status", 4'h8, 32'h0000_0806);
    check("drain_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 8; i++) read_check($sformatf("drain_rx%0d", i), 4'h4, 32'hA0 + 32'(i));

    // half-bit glitch on rx is rejected
    loop = 1'b0;
    rx_drv = 1'b1;
    bus_write(4'hC, 32'h0001_0002);
    repeat (20) @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    read_check("glitch_status", 4'h8, 32'h0000_000A);

    // soft reset in the middle of a TX frame
    bus_write(4'hC, 32'h0001_0001);
    bus_write(4'h0, 32'h0000_0000);
    bus_write(4'h0, 32'h0000_0000);
    repeat (100) @(negedge clk);
    read_check("busy_status", 4'h8, 32'h0000_0018);
    check("mid_frame_low", 32'(tx_out), 32'd0);
    bus_write(4'hC, 32'h0001_0005);
    check("soft_tx_out", 32'(tx_out), 32'd1);
    read_check("soft_status", 4'h8, 32'h0000_000A);
    read_check("soft_ctrl", 4'hC, 32'h0001_0001);

    // hard reset mid-traffic
    bus_write(4'hC, 32'h0001_0081);
    bus_write(4'h0, 32'h0000_0000);
    repeat (60) @(negedge clk);
    check("pre_rst_irq", 32'(irq), 32'd1);
    rst_n = 1'b0;
    #1;
    check("hrst_tx_out", 32'(tx_out), 32'd1);
    check("hrst_irq", 32'(irq), 32'd0);
    check("hrst_rdata", readed_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_check("hrst_status", 4'h8, 32'h0000_000A);
    read_check("hrst_ctrl", 4'hC, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Memory-mapped UART with programmable baud divisor, optional parity, one or two stop bits, and parametrised TX/RX FIFOs. Sits on the core's data bus in the 0x8000_0000–0x8000_000F window, selected by sel_uart. The block includes error detection with sticky flags and a level interrupt. It replaces the fixed single-byte UART register file.

Parameters:
FIFO_DEPTH, 8, entries per TX and RX FIFO; must be a power of 2, ≥2.
OVERSAMPLE, 16, baud ticks per bit; must be even, ≥4.
DIV_WIDTH, 16, width of the baud divisor field; ≤16.
DEFAULT_DIV, 0, reset value of the divisor.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; asynchronous, active-low.
sel_uart  input  1  address decode hit for the UART window.
mem_write  input  1  write strobe.
mem_read  input  1  read strobe; RXDATA pop qualifier.
addr  input  4  byte offset; word-aligned, addr[3:2] decoded, addr[1:0] ignored.
write_data  input  32  bus write data.
readed_data  output  32  registered read data.
rx_in  input  1  serial input; asynchronous.
tx_out  output  1  serial output; idles high.
irq  output  1  level interrupt.

Behaviour:
- Register map:
  - 0x0 TXDATA (W): push write_data[7:0]. Dropped if TX FIFO full. Reads return 0.
  - 0x4 RXDATA (R): [7:0] = FIFO head; the read pops it. Empty read returns 0 with no pop. Writes ignored.
  - 0x8 STATUS:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy (FSM not IDLE).
    - [5] parity_err, [6] frame_err, [7] overrun — all sticky.
    - [15:8] rx_count. Other bits 0.
    - Write-1-to-clear on [7:5]; other bits read-only.
  - 0xC CTRL (RW):
    - [0] tx_en, [1] rx_en, [2] soft_rst (self-clearing, reads 0).
    - [3] parity_en, [4] parity_odd, [5] two_stop, [6] rx_irq_en, [7] tx_irq_en.
    - [16+DIV_WIDTH-1:16] div. Reset value 0 except div = DEFAULT_DIV.
- Bus timing:
  - Write effective at the clk edge where sel_uart & mem_write.
  - Read: readed_data loaded at the edge where sel_uart & mem_read; 1-cycle latency; holds value otherwise.
  - Simultaneous mem_read & mem_write: write only.
- Reset (rst_n low):
  - tx_out=1, readed_data=0, irq=0.
  - FIFOs empty, FSMs IDLE, CTRL and flags as above.
- soft_rst: at the next edge, flushes both FIFOs, forces both FSMs IDLE, sets tx_out=1 and clears sticky flags. CTRL other fields keep the written value.
- Baud generator:
  - Counter 0..div; tick when count==div, so the tick period is div+1 clks.
  - Free-running while tx_en|rx_en; held at 0 otherwise.
- TX FSM:
  - States: IDLE→START→DATA(8, LSB first)→[PARITY]→STOP(1 or 2)→IDLE. Each bit = OVERSAMPLE ticks.
  - Leaves IDLE when tx_en & !tx_empty; pops the byte on the IDLE→START transition.
  - Parity bit = ^data ^ parity_odd.
  - Clearing tx_en mid-frame: the frame completes, then the FSM waits in IDLE.
- RX FSM:
  - rx_in passes through a 2-flop synchroniser.
  - IDLE: a falling edge starts START.
  - START: after OVERSAMPLE/2 ticks, rx still 0 → DATA; else back to IDLE (glitch reject).
  - DATA/PARITY/STOP: sampled every OVERSAMPLE ticks (mid-bit). Second stop bit not checked.
  - On the first stop sample:
    - stop==0 → set frame_err, discard byte.
    - parity mismatch → set parity_err, discard byte.
    - otherwise push; if RX FIFO full, discard and set overrun.
  - rx_en low forces IDLE immediately.
- FIFOs:
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty), registered.

Test Plan:
- Reset: assert rst_n=0 mid-traffic → tx_out=1, irq=0, readed_data=0; STATUS read = 0x0000_000A.
- Loopback (rx_in=tx_out): CTRL=0x0001_0003, TXDATA=0x55 → start bit 32 clks low, frame 320 clks. After the frame, RXDATA read = 0x55, STATUS[3]=1.
- Parity: CTRL=0x0001_001B, send 0x07 → parity bit 0. Bench drives 0x07 with parity 1 → STATUS[5]=1, rx_empty=1. Write STATUS=0x20 → [5]=0.
- Overrun: FIFO_DEPTH=8, 9 frames received without reads → rx_count=8, overrun=1, reads return bytes 1–8 in order.
- TX full: tx_en=0, write 10 bytes → tx_full after 8th, bytes 9–10 dropped. Then set tx_en=1 → exactly 8 frames, tx_empty=1, irq with tx_irq_en.
- Glitch and soft reset: rx_in low for 8 ticks (div=1 → 16 clks) → no byte, no flags. Write soft_rst mid-TX-frame → tx_out=1 next cycle, FIFOs empty, tx_busy=0.
